// File: rtl/alut_pkg28.sv
// ---------------------------------------------------------------------------
// alut_pkg28
// Shared constants, FSM state type and an entry-packing helper for the ALUT
// memory controller slice.
// Entry layout: bit 82 = valid, [49:48] = port, [47:0] = MAC address.
// ---------------------------------------------------------------------------
package alut_pkg28;

    localparam int ALUT_DW      = 83;
    localparam int ALUT_AW      = 8;
    localparam int ALUT_DEPTH   = 256;
    localparam int ALUT_VLD_BIT = 82;

    localparam int ALUT_PORT_HI = 49;
    localparam int ALUT_PORT_LO = 48;
    localparam int ALUT_MAC_HI  = 47;
    localparam int ALUT_MAC_LO  = 0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } alut_state_e;

    // Builds a table entry from its fields; unused bits are zero.
    function automatic logic [ALUT_DW-1:0] alut_entry(
        input logic                                   vld,
        input logic [ALUT_PORT_HI-ALUT_PORT_LO:0]     port,
        input logic [ALUT_MAC_HI-ALUT_MAC_LO:0]       mac
    );
        logic [ALUT_DW-1:0] e;
        e                            = '0;
        e[ALUT_VLD_BIT]              = vld;
        e[ALUT_PORT_HI:ALUT_PORT_LO] = port;
        e[ALUT_MAC_HI:ALUT_MAC_LO]   = mac;
        return e;
    endfunction

endpackage

// File: rtl/alut_mem_ctrl28_if.sv
// ---------------------------------------------------------------------------
// alut_mem_ctrl28_if
// Requester-facing bundle of the ALUT memory controller.
//   master : requester side (address checker + age checker, status sink)
//   slave  : controller side
// Signals keep the original port names of the flat controller.
// ---------------------------------------------------------------------------
interface alut_mem_ctrl28_if;

    logic                                  add_check_active28;
    logic [alut_pkg28::ALUT_AW-1:0]        mem_addr_add28;
    logic                                  mem_write_add28;
    logic [alut_pkg28::ALUT_DW-1:0]        mem_write_data_add28;
    logic [alut_pkg28::ALUT_AW-1:0]        mem_addr_age28;
    logic                                  mem_write_age28;
    logic [alut_pkg28::ALUT_DW-1:0]        mem_write_data_age28;
    logic [alut_pkg28::ALUT_DW-1:0]        mem_read_data_add28;
    logic [alut_pkg28::ALUT_DW-1:0]        mem_read_data_age28;
    logic                                  mem_init_busy28;
    logic [alut_pkg28::ALUT_AW:0]          valid_count28;
    logic                                  par_err28;
    logic [alut_pkg28::ALUT_AW-1:0]        par_err_addr28;

    modport master (
        output add_check_active28,
        output mem_addr_add28, mem_write_add28, mem_write_data_add28,
        output mem_addr_age28, mem_write_age28, mem_write_data_age28,
        input  mem_read_data_add28, mem_read_data_age28,
        input  mem_init_busy28, valid_count28,
        input  par_err28, par_err_addr28
    );

    modport slave (
        input  add_check_active28,
        input  mem_addr_add28, mem_write_add28, mem_write_data_add28,
        input  mem_addr_age28, mem_write_age28, mem_write_data_age28,
        output mem_read_data_add28, mem_read_data_age28,
        output mem_init_busy28, valid_count28,
        output par_err28, par_err_addr28
    );

endinterface

// File: rtl/alut_mem_array28.sv
// ---------------------------------------------------------------------------
// alut_mem_array28
// DEPTH x DW storage with a registered read port (latency 1, write-through).
// Optional feature macro: ALUT_MEM_PARITY_EN adds one even-parity bit per
// entry and a registered parity-error pulse aligned with the read data.
// Ports:
//   pclk28, n_p_reset28 : clock, async active-low reset
//   we, addr, wdata     : write strobe / address / data
//   rd_en               : load the read register this cycle
//   rdata               : registered read data
//   par_err, par_err_addr : parity error pulse and last failing address
// ---------------------------------------------------------------------------
module alut_mem_array28 #(
    parameter int DW    = 83,
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          pclk28,
    input  logic          n_p_reset28,
    input  logic          we,
    input  logic          rd_en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          par_err,
    output logic [AW-1:0] par_err_addr
);

`ifdef ALUT_MEM_PARITY_EN
    localparam int EW = DW + 1;
`else
    localparam int EW = DW;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] wentry;
    logic [EW-1:0] rentry;

`ifdef ALUT_MEM_PARITY_EN
    assign wentry = {^wdata, wdata};
`else
    assign wentry = wdata;
`endif

    assign rentry = mem[addr];

    // Storage is not reset; the INIT sweep clears it.
    always_ff @(posedge pclk28) begin
        if (we) begin
            mem[addr] <= wentry;
        end
    end

    always_ff @(posedge pclk28 or negedge n_p_reset28) begin
        if (!n_p_reset28) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= we ? wdata : rentry[DW-1:0];
        end
    end

`ifdef ALUT_MEM_PARITY_EN
    // Only stored entries are checked; write-through data is fresh.
    logic chk_fail;
    assign chk_fail = rd_en && !we && (^rentry);

    always_ff @(posedge pclk28 or negedge n_p_reset28) begin
        if (!n_p_reset28) begin
            par_err      <= 1'b0;
            par_err_addr <= '0;
        end else begin
            par_err <= chk_fail;
            if (chk_fail) begin
                par_err_addr <= addr;
            end
        end
    end
`else
    assign par_err      = 1'b0;
    assign par_err_addr = '0;
`endif

endmodule

// File: rtl/alut_mem_ctrl28.sv
// ---------------------------------------------------------------------------
// alut_mem_ctrl28
// Responder side of the ALUT memory interface. Clears all entries after reset
// (INIT sweep, 256 cycles, mem_init_busy28 high), then serves either the
// address checker or the age checker, selected by add_check_active28.
// Tracks the number of valid entries (bit 82) in valid_count28.
// Optional feature macro: ALUT_MEM_PARITY_EN (per-entry parity, par_err28 /
// par_err_addr28); when undefined those outputs are tied to 0.
// Ports:
//   pclk28       : clock
//   n_p_reset28  : async active-low reset
//   mem_if       : alut_mem_ctrl28_if.slave (requester ports + status)
// ---------------------------------------------------------------------------
module alut_mem_ctrl28
    import alut_pkg28::*;
#(
    parameter int DW    = ALUT_DW,
    parameter int AW    = ALUT_AW,
    parameter int DEPTH = ALUT_DEPTH
) (
    input  logic              pclk28,
    input  logic              n_p_reset28,
    alut_mem_ctrl28_if.slave  mem_if
);

    alut_state_e   state, state_nxt;
    logic [AW-1:0] ptr, ptr_nxt;

    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          arr_we;
    logic          arr_rd_en;
    logic [AW-1:0] arr_addr;
    logic [DW-1:0] arr_wdata;
    logic [DW-1:0] arr_rdata;

    logic [DEPTH-1:0] vld_shadow;
    logic [AW:0]      valid_count;

    // Requester port select; the unselected port is fully ignored.
    always_comb begin
        if (mem_if.add_check_active28) begin
            sel_we    = mem_if.mem_write_add28;
            sel_addr  = mem_if.mem_addr_add28;
            sel_wdata = mem_if.mem_write_data_add28;
        end else begin
            sel_we    = mem_if.mem_write_age28;
            sel_addr  = mem_if.mem_addr_age28;
            sel_wdata = mem_if.mem_write_data_age28;
        end
    end

    always_ff @(posedge pclk28 or negedge n_p_reset28) begin
        if (!n_p_reset28) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt               = state;
        ptr_nxt                 = ptr;
        arr_we                  = 1'b0;
        arr_rd_en               = 1'b0;
        arr_addr                = ptr;
        arr_wdata               = '0;
        mem_if.mem_init_busy28  = 1'b1;
        case (state)
            INIT: begin
                arr_we   = 1'b1;
                arr_addr = ptr;
                ptr_nxt  = ptr + AW'(1);
                if (ptr == '1) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                mem_if.mem_init_busy28 = 1'b0;
                arr_rd_en              = 1'b1;
                arr_we                 = sel_we;
                arr_addr               = sel_addr;
                arr_wdata              = sel_wdata;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // Count changes only on a valid-bit transition seen against the shadow,
    // so rewriting an already-valid entry leaves the count alone.
    always_ff @(posedge pclk28 or negedge n_p_reset28) begin
        if (!n_p_reset28) begin
            vld_shadow  <= '0;
            valid_count <= '0;
        end else if (state == RUN && sel_we) begin
            vld_shadow[sel_addr] <= sel_wdata[ALUT_VLD_BIT];
            if (!vld_shadow[sel_addr] && sel_wdata[ALUT_VLD_BIT]) begin
                valid_count <= valid_count + (AW+1)'(1);
            end else if (vld_shadow[sel_addr] && !sel_wdata[ALUT_VLD_BIT]) begin
                valid_count <= valid_count - (AW+1)'(1);
            end
        end
    end

    alut_mem_array28 #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_array (
        .pclk28       (pclk28),
        .n_p_reset28  (n_p_reset28),
        .we           (arr_we),
        .rd_en        (arr_rd_en),
        .addr         (arr_addr),
        .wdata        (arr_wdata),
        .rdata        (arr_rdata),
        .par_err      (mem_if.par_err28),
        .par_err_addr (mem_if.par_err_addr28)
    );

    assign mem_if.mem_read_data_add28 = arr_rdata;
    assign mem_if.mem_read_data_age28 = arr_rdata;
    assign mem_if.valid_count28       = valid_count;

endmodule
